// File: rtl/uart_rx_fifo_if.sv
// Read-side handshake bundle of uart_rx_fifo: head character, its status
// flags and the valid/ready pair used to pop it.
interface uart_rx_fifo_if;
  logic [7:0] rd_data;
  logic [2:0] rd_status;
  logic       rd_valid;
  logic       rd_ready;

  modport master (
    output rd_data,
    output rd_status,
    output rd_valid,
    input  rd_ready
  );

  modport slave (
    input  rd_data,
    input  rd_status,
    input  rd_valid,
    output rd_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled UART receiver with 3-sample majority vote,
// runtime frame format, parity/framing/break status and a first-word
// fall-through FIFO on the read side.
// Optional idle timeout is compiled in with macro UART_RX_TIMEOUT_EN.
module uart_rx_fifo #(
  parameter int DIV_W        = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  input  logic [1:0]         data_bits,
  input  logic               parity_en,
  input  logic [1:0]         parity_mode,
  input  logic               two_stop,
  input  logic [DIV_W-1:0]   clk_div,
  uart_rx_fifo_if.master     rd,
  output logic [CNT_W-1:0]   fifo_count,
  output logic               overflow,
  input  logic               clr_overflow,
  output logic               busy,
  output logic               timeout
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BRKWAIT} state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity bit value that makes the frame correct for the given mode.
  function automatic logic parity_exp(input logic [1:0] mode, input logic [7:0] d);
    logic r;
    case (mode)
      2'b00:   r = 1'b0;
      2'b01:   r = ^d;
      2'b10:   r = ~^d;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  logic [1:0]       sync_q, sync_d;
  logic             rx_s;
  state_t           state_q, state_d;
  logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]       sub_q, sub_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             s7_q, s7_d, s8_q, s8_d;
  logic [7:0]       data_q, data_d;
  logic             par_bit_q, par_bit_d, par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic [1:0]       dbits_q, dbits_d, pmode_q, pmode_d;
  logic             pen_q, pen_d, two_q, two_d;
  logic             tick, decide, bit_val, fe_now, push;
  logic [10:0]      push_word;

  logic [10:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d, full, pop, push_acc;

  assign rx_s    = sync_q[1];
  assign tick    = (state_q != IDLE) && (tick_cnt_q == clk_div);
  assign decide  = tick && (sub_q == 4'd9);
  assign bit_val = maj3(s7_q, s8_q, rx_s);

  // Two-flop synchroniser for the asynchronous rx pad.
  always_comb sync_d = {sync_q[0], rx};

  // Synchroniser register; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= sync_d;
  end

  // Receiver FSM, oversampling counters and character assembly.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    sub_d      = sub_q;
    bit_idx_d  = bit_idx_q;
    s7_d       = s7_q;
    s8_d       = s8_q;
    data_d     = data_q;
    par_bit_d  = par_bit_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    dbits_d    = dbits_q;
    pen_d      = pen_q;
    pmode_d    = pmode_q;
    two_d      = two_q;
    push       = 1'b0;
    fe_now     = frm_err_q | ~bit_val;
    push_word  = {fe_now & (data_q == 8'h00) & ~(pen_q & par_bit_q), fe_now, par_err_q, data_q};
    if (state_q == IDLE) begin
      tick_cnt_d = '0;
      sub_d      = '0;
      if (!rx_s) begin
        state_d   = START;
        bit_idx_d = '0;
        data_d    = '0;
        par_bit_d = 1'b0;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;
        dbits_d   = data_bits;
        pen_d     = parity_en;
        pmode_d   = parity_mode;
        two_d     = two_stop;
      end
    end else begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + DIV_W'(1);
      if (tick) sub_d = sub_q + 4'd1;
      if (tick && (sub_q == 4'd7)) s7_d = rx_s;
      if (tick && (sub_q == 4'd8)) s8_d = rx_s;
      if (decide) begin
        case (state_q)
          START: state_d = bit_val ? IDLE : DATA;
          DATA: begin
            data_d[bit_idx_q] = bit_val;
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == ({1'b0, dbits_q} + 3'd4)) state_d = pen_q ? PARITY : STOP1;
          end
          PARITY: begin
            par_bit_d = bit_val;
            par_err_d = bit_val ^ parity_exp(pmode_q, data_q);
            state_d   = STOP1;
          end
          STOP1: begin
            frm_err_d = fe_now;
            if (fe_now || !two_q) begin
              push    = 1'b1;
              state_d = bit_val ? IDLE : BRKWAIT;
            end else begin
              state_d = STOP2;
            end
          end
          STOP2: begin
            frm_err_d = fe_now;
            push      = 1'b1;
            state_d   = bit_val ? IDLE : BRKWAIT;
          end
          default: ;
        endcase
      end
      // A held-low line after the stop sample must go high before re-arming.
      if ((state_q == BRKWAIT) && rx_s) state_d = IDLE;
    end
  end

  // Receiver control state; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      sub_q      <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      sub_q      <= sub_d;
    end
  end

  // Receiver datapath registers: samples, character, flags and latched format.
  always_ff @(posedge clk) begin
    bit_idx_q <= bit_idx_d;
    s7_q      <= s7_d;
    s8_q      <= s8_d;
    data_q    <= data_d;
    par_bit_q <= par_bit_d;
    par_err_q <= par_err_d;
    frm_err_q <= frm_err_d;
    dbits_q   <= dbits_d;
    pen_q     <= pen_d;
    pmode_q   <= pmode_d;
    two_q     <= two_d;
  end

  // FIFO pointer/count/overflow bookkeeping; a full FIFO still accepts a push when popped.
  always_comb begin
    full       = (count_q == CNT_W'(FIFO_DEPTH));
    pop        = (count_q != '0) && rd.rd_ready;
    push_acc   = push && (!full || pop);
    wr_ptr_d   = push_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push_acc) - CNT_W'(pop);
    overflow_d = (push && full && !pop) | (overflow_q & ~clr_overflow);
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage: {break, frame_err, parity_err, data}.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= push_word;
  end

  assign rd.rd_valid  = (count_q != '0);
  assign rd.rd_data   = rd.rd_valid ? mem_q[rd_ptr_q][7:0]  : 8'h00;
  assign rd.rd_status = rd.rd_valid ? mem_q[rd_ptr_q][10:8] : 3'b000;
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;
  assign busy         = (state_q != IDLE);

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_LIMIT = 16 * TIMEOUT_BITS;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  logic [DIV_W-1:0] ftick_cnt_q, ftick_cnt_d;
  logic [TO_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic             timeout_q, timeout_d, ftick, start_evt;

  // Free-running tick source and idle-character counter for the timeout flag.
  always_comb begin
    ftick       = (ftick_cnt_q >= clk_div);
    ftick_cnt_d = ftick ? '0 : ftick_cnt_q + DIV_W'(1);
    start_evt   = (state_q == IDLE) && !rx_s;
    idle_cnt_d  = idle_cnt_q;
    if (pop || (state_q != IDLE) || !rd.rd_valid) idle_cnt_d = '0;
    else if (ftick && (idle_cnt_q != TO_W'(TO_LIMIT))) idle_cnt_d = idle_cnt_q + TO_W'(1);
    timeout_d = timeout_q;
    if (pop || start_evt) timeout_d = 1'b0;
    else if (idle_cnt_q == TO_W'(TO_LIMIT)) timeout_d = 1'b1;
  end

  // Timeout control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ftick_cnt_q <= '0;
      idle_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      ftick_cnt_q <= ftick_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver with 16x oversampling, 3-sample majority vote, runtime-configurable frame format, full parity checking, framing and break detection.
- Received characters and their per-character status go into an internal FIFO with a valid/ready read port.
- Sits between the pad-side rx line and the register/bus front-end.
- Runs entirely on clk; the divider produces a one-cycle sample-enable, never a derived clock.

Parameters:
- DIV_W, 16, width of clk_div.
- FIFO_DEPTH, 8, FIFO entries; power of two, at least 2.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count.
- TIMEOUT_BITS, 32, idle bit periods before timeout (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input, idle high.
- data_bits  in  2  character length = data_bits+5 (5..8).
- parity_en  in  1  parity bit present.
- parity_mode  in  2  00 space, 01 even, 10 odd, 11 mark.
- two_stop  in  1  two stop bits checked.
- clk_div  in  DIV_W  tick period = clk_div+1 clocks; one bit = 16 ticks.
- rd_data  out  8  head character, right-justified, unused upper bits 0.
- rd_status  out  3  {break, frame_err, parity_err} of the head entry.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  pop the head entry when rd_valid is high.
- fifo_count  out  CNT_W  entries held.
- overflow  out  1  sticky; a character was dropped.
- clr_overflow  in  1  clears overflow.
- busy  out  1  receiver not in IDLE.
- timeout  out  1  see Optional Feature.

Behaviour:
- Reset values: rd_valid=0, fifo_count=0, overflow=0, busy=0, timeout=0, rd_data=0, rd_status=0. FIFO pointers cleared. Synchroniser flops set to 1.
- rx passes through a 2-flop synchroniser; all further references to rx mean the synchronised value.
- Tick counter:
  - Runs only outside IDLE; forced to 0 in IDLE.
  - Emits a one-cycle tick when the count equals clk_div, then wraps to 0.
  - clk_div=0 gives a tick every cycle.
- Bit timing: a 4-bit subcounter counts ticks 0..15 within each bit. The bit value is the majority of rx sampled at ticks 7, 8 and 9, and is decided at tick 9.
- Config latch: data_bits, parity_en, parity_mode and two_stop are latched on the IDLE->START transition. Mid-frame config changes have no effect.
- FSM:
  - IDLE: on rx=0, go to START with subcounter=0.
  - START: at decision, 1 -> IDLE (glitch, nothing pushed); 0 -> DATA.
  - DATA: bits are taken LSB first, data_bits+5 of them. After the last bit: -> PARITY if parity_en, else -> STOP1.
  - PARITY: compare the sampled bit with the expected value.
    - even: XOR(data) ^ p must be 0.
    - odd: XOR(data) ^ p must be 1.
    - mark: p must be 1.
    - space: p must be 0.
    - Mismatch sets parity_err.
  - STOP1: sample 0 sets frame_err.
    - If frame_err is set, or two_stop=0: push the character at decision and go to BRKWAIT if rx=0, else IDLE.
    - Otherwise -> STOP2.
  - STOP2: sample 0 sets frame_err. Push, then go to BRKWAIT if rx=0, else IDLE.
  - BRKWAIT: stay until rx=1, then -> IDLE. Nothing is pushed.
- break = frame_err AND all data bits 0 AND parity bit 0 (when present).
- busy=1 in every state except IDLE.
- FIFO:
  - First-word fall-through; a pushed entry appears at the head/rd_valid on the cycle after the push.
  - Pop occurs on a cycle with rd_valid && rd_ready.
  - Push while full without a pop in the same cycle: the entry is dropped and overflow=1.
  - Push and pop together while full: both accepted, count unchanged.
  - Push and pop together while empty: impossible, since rd_valid=0.
  - rd_ready while empty is ignored.
- overflow: a set event and clr_overflow in the same cycle leaves overflow=1.
- Reset mid-frame: the frame is abandoned, the FIFO is emptied, and the FSM returns to IDLE on the next cycle.

Optional Feature:
- Macro: UART_RX_TIMEOUT_EN.
- With the macro defined:
  - An idle counter counts ticks of a free-running tick generator while the FSM is in IDLE and rd_valid=1.
  - It clears on a pop, on leaving IDLE, or when the FIFO becomes empty.
  - timeout is set when the count reaches 16*TIMEOUT_BITS, and stays high until the next pop or start bit.
- Without the macro: timeout is tied to 0, no counter logic is present, and TIMEOUT_BITS is unused.

Test Plan:
- clk_div=3, 8N1, send 0xA5 with rd_ready=0 -> one entry: rd_data=0xA5, rd_status=000, fifo_count=1, rd_valid high 1 cycle after the stop decision.
- 7E2, send 0x35 with correct parity 0, then 0x35 with parity 1 -> second entry rd_status=001. Drop the second stop bit of a third frame -> rd_status=010.
- 5-bit, no parity: hold rx=0 for 3 character times, then release -> one entry rd_data=0x00, rd_status=110. No further entries until rx has returned high and a new start bit arrives.
- Single-clock rx low pulse of 20 clocks at clk_div=3 (start decision at 40 clocks) -> returns to IDLE, no push, busy drops.
- FIFO_DEPTH=8: push 9 characters with no reads -> fifo_count=8, overflow=1, 9th character absent. Then pop 8 -> data in order 1..8. clr_overflow -> overflow=0.
- With UART_RX_TIMEOUT_EN, TIMEOUT_BITS=4: one character, then line idle -> timeout rises after 64 ticks and clears on the pop. Without the macro, timeout stays 0.
